// File: rtl/mac_acc_array.sv
// mac_acc_array: N_TAP-way signed multiply-accumulate engine.
// Input register, product register, fully registered adder tree, then a
// group accumulator driven by first_i/last_i beat markers.
// Optional build macro MAC_ACC_SAT_EN: saturating accumulation with a sticky
// per-group overflow flag reported on ovf_o. Without it, accumulation wraps
// and ovf_o is tied low.

module mac_acc_array #(
    parameter int N_TAP = 9,
    parameter int DW    = 8,
    parameter int ACCW  = 24
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  vld_i,
    input  logic                  first_i,
    input  logic                  last_i,
    input  logic [N_TAP*DW-1:0]   win,
    input  logic [N_TAP*DW-1:0]   din,
    output logic [ACCW-1:0]       acc_o,
    output logic                  vld_o,
    output logic                  ovf_o
);

    localparam int T  = $clog2(N_TAP);
    localparam int PW = 2 * DW;
    localparam int SW = PW + T;

    // Number of live nodes at tree level l (level 0 = products).
    function automatic int lvl_cnt(input int l);
        int c;
        c = N_TAP;
        for (int j = 0; j < l; j++) c = (c + 1) / 2;
        return c;
    endfunction

    logic signed [DW-1:0]   w_p0   [N_TAP];
    logic signed [DW-1:0]   x_p0   [N_TAP];
    // tree_p[0] is the product stage (p1); tree_p[l] is tree level l (stage p(1+l)).
    logic signed [SW-1:0]   tree_p [T+1][N_TAP];
    // Control delay line; bit k is aligned with pipeline stage pk.
    logic [T+1:0]           vld_p;
    logic [T+1:0]           first_p;
    logic [T+1:0]           last_p;

    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] acc_base;
    logic signed [ACCW-1:0] acc_nxt;

`ifdef MAC_ACC_SAT_EN
    localparam int EW = ((ACCW > SW) ? ACCW : SW) + 1;

    logic signed [EW-1:0]   sum_e;
    logic                   clamp;
    logic                   ovf_flag;
    logic                   ovf_flag_nxt;

    // Clamp a wide sum into ACCW signed range; MSB of result flags a clamp.
    function automatic logic [ACCW:0] sat_acc(input logic signed [EW-1:0] s);
        logic signed [EW-1:0] hi;
        logic signed [EW-1:0] lo;
        hi = {{(EW-ACCW+1){1'b0}}, {(ACCW-1){1'b1}}};
        lo = ~hi;
        if (s > hi)      return {1'b1, hi[ACCW-1:0]};
        else if (s < lo) return {1'b1, lo[ACCW-1:0]};
        else             return {1'b0, s[ACCW-1:0]};
    endfunction
`endif

    // ---- stage p0: operand capture, only on valid beats
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < N_TAP; k++) begin
                w_p0[k] <= '0;
                x_p0[k] <= '0;
            end
        end else if (vld_i) begin
            for (int k = 0; k < N_TAP; k++) begin
                w_p0[k] <= win[k*DW +: DW];
                x_p0[k] <= din[k*DW +: DW];
            end
        end
    end

    // Control markers travel alongside the data through every stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p   <= '0;
            first_p <= '0;
            last_p  <= '0;
        end else begin
            vld_p   <= {vld_p[T:0],   vld_i};
            first_p <= {first_p[T:0], vld_i & first_i};
            last_p  <= {last_p[T:0],  vld_i & last_i};
        end
    end

    // ---- stage p1: products; stages p2..p(1+T): pairwise adder tree
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int l = 0; l <= T; l++)
                for (int i = 0; i < N_TAP; i++)
                    tree_p[l][i] <= '0;
        end else begin
            for (int i = 0; i < N_TAP; i++)
                tree_p[0][i] <= SW'(PW'(w_p0[i]) * PW'(x_p0[i]));
            for (int l = 1; l <= T; l++) begin
                for (int i = 0; i < N_TAP; i++) begin
                    if (2*i + 1 < lvl_cnt(l-1))
                        tree_p[l][i] <= tree_p[l-1][2*i] + tree_p[l-1][2*i+1];
                    else if (2*i < lvl_cnt(l-1))
                        tree_p[l][i] <= tree_p[l-1][2*i];   // odd leftover passes through
                    else
                        tree_p[l][i] <= '0;
                end
            end
        end
    end

    // Next accumulator value: restart on first, else add tree sum.
    always_comb begin
        acc_base = first_p[T+1] ? '0 : acc;
`ifdef MAC_ACC_SAT_EN
        sum_e            = EW'(acc_base) + EW'(tree_p[T][0]);
        {clamp, acc_nxt} = sat_acc(sum_e);
        ovf_flag_nxt     = (first_p[T+1] ? 1'b0 : ovf_flag) | clamp;
`else
        acc_nxt          = acc_base + ACCW'(tree_p[T][0]);
`endif
    end

    // ---- stage acc: accumulate, emit and clear on last
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc   <= '0;
            acc_o <= '0;
            vld_o <= 1'b0;
        end else begin
            vld_o <= 1'b0;
            if (vld_p[T+1]) begin
                if (last_p[T+1]) begin
                    acc_o <= acc_nxt;
                    vld_o <= 1'b1;
                    acc   <= '0;
                end else begin
                    acc   <= acc_nxt;
                end
            end
        end
    end

`ifdef MAC_ACC_SAT_EN
    // Sticky per-group clamp flag, reported with the group result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_flag <= 1'b0;
            ovf_o    <= 1'b0;
        end else if (vld_p[T+1]) begin
            if (last_p[T+1]) begin
                ovf_o    <= ovf_flag_nxt;
                ovf_flag <= 1'b0;
            end else begin
                ovf_flag <= ovf_flag_nxt;
            end
        end
    end
`else
    assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_mac_acc_array.sv
// Bench for mac_acc_array: two instances (ACCW=24 and ACCW=18) share one
// beat stream; an integer model predicts every group result and its cycle.

module tb_mac_acc_array;

    localparam int N  = 9;
    localparam int DW = 8;
    localparam int LAT = 7;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                vld_i = 1'b0;
    logic                first_i = 1'b0;
    logic                last_i = 1'b0;
    logic [N*DW-1:0]     win = '0;
    logic [N*DW-1:0]     din = '0;
    logic signed [23:0]  acc24;
    logic                vld24;
    logic                ovf24;
    logic signed [17:0]  acc18;
    logic                vld18;
    logic                ovf18;

    mac_acc_array #(.N_TAP(N), .DW(DW), .ACCW(24)) u_dut (
        .clk(clk), .rstn(rstn), .vld_i(vld_i), .first_i(first_i), .last_i(last_i),
        .win(win), .din(din), .acc_o(acc24), .vld_o(vld24), .ovf_o(ovf24)
    );

    mac_acc_array #(.N_TAP(N), .DW(DW), .ACCW(18)) u_dut18 (
        .clk(clk), .rstn(rstn), .vld_i(vld_i), .first_i(first_i), .last_i(last_i),
        .win(win), .din(din), .acc_o(acc18), .vld_o(vld18), .ovf_o(ovf18)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     due;
        longint a24;
        longint a18;
        bit     o24;
        bit     o18;
    } exp_t;

    exp_t   q[$];
    longint m_acc24 = 0, m_acc18 = 0;
    bit     m_f24 = 0, m_f18 = 0;
    longint hold24 = 0, hold18 = 0;
    longint got24 = 0, got18 = 0;
    bit     gotovf18 = 0;
    int     pulses = 0;
    int     n_cmp = 0, n_bad = 0;
    bit     ev;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Fit an exact integer into a w-bit accumulator (wrap or clamp).
    function automatic longint fit(input longint v, input int w, output bit clamp);
        longint hi, lo, m;
        hi = (longint'(1) <<< (w-1)) - 1;
        lo = -(longint'(1) <<< (w-1));
        clamp = 1'b0;
        m = v;
`ifdef MAC_ACC_SAT_EN
        if (v > hi) begin clamp = 1'b1; m = hi; end
        else if (v < lo) begin clamp = 1'b1; m = lo; end
`else
        m = v & ((longint'(1) <<< w) - 1);
        if (m > hi) m = m - (longint'(1) <<< w);
`endif
        return m;
    endfunction

    task automatic model_beat(input bit f, input bit l, input logic [N*DW-1:0] w,
                              input logic [N*DW-1:0] x);
        longint s;
        logic signed [DW-1:0] a, b;
        bit c24, c18;
        exp_t e;
        s = 0;
        for (int k = 0; k < N; k++) begin
            a = w[k*DW +: DW];
            b = x[k*DW +: DW];
            s += longint'(a) * longint'(b);
        end
        m_acc24 = fit((f ? 0 : m_acc24) + s, 24, c24);
        m_acc18 = fit((f ? 0 : m_acc18) + s, 18, c18);
        m_f24 = (f ? 1'b0 : m_f24) | c24;
        m_f18 = (f ? 1'b0 : m_f18) | c18;
        if (l) begin
            e.due = cyc + LAT;
            e.a24 = m_acc24; e.a18 = m_acc18;
            e.o24 = m_f24;   e.o18 = m_f18;
            q.push_back(e);
            m_acc24 = 0; m_acc18 = 0; m_f24 = 0; m_f18 = 0;
        end
    endtask

    task automatic beat(input bit v, input bit f, input bit l,
                        input logic [N*DW-1:0] w, input logic [N*DW-1:0] x);
        @(posedge clk); #1;
        vld_i = v; first_i = f; last_i = l; win = w; din = x;
        if (v) model_beat(f, l, w, x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rstn = 1'b0; vld_i = 1'b0;
        q.delete();
        m_acc24 = 0; m_acc18 = 0; m_f24 = 0; m_f18 = 0;
        #1;
        check("rst_now_acc24", acc24, 0);
        check("rst_now_vld24", vld24, 0);
        check("rst_now_ovf24", ovf24, 0);
        check("rst_now_acc18", acc18, 0);
        idle(n);
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    function automatic logic [N*DW-1:0] rep(input logic [DW-1:0] v);
        return {N{v}};
    endfunction

    function automatic logic [N*DW-1:0] one(input logic [DW-1:0] v);
        return {{((N-1)*DW){1'b0}}, v};
    endfunction

    function automatic logic [N*DW-1:0] rnd_vec();
        logic [N*DW-1:0] r;
        for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 5))
                0:       r[k*DW +: DW] = 8'h80;
                1:       r[k*DW +: DW] = 8'h7f;
                default: r[k*DW +: DW] = 8'($urandom);
            endcase
        end
        return r;
    endfunction

    // Every cycle: outputs against the model schedule and held value.
    always @(negedge clk) begin
        if (!rstn) begin
            hold24 = 0; hold18 = 0;
            check("rst_acc24", acc24, 0);
            check("rst_vld24", vld24, 0);
            check("rst_ovf24", ovf24, 0);
            check("rst_acc18", acc18, 0);
            check("rst_vld18", vld18, 0);
            check("rst_ovf18", ovf18, 0);
        end else begin
            ev = (q.size() > 0) && (q[0].due == cyc);
            if (ev) begin
                hold24 = q[0].a24;
                hold18 = q[0].a18;
            end
            check("vld24", vld24, ev);
            check("acc24", acc24, hold24);
            check("vld18", vld18, ev);
            check("acc18", acc18, hold18);
            if (ev) begin
                check("ovf24", ovf24, q[0].o24);
                check("ovf18", ovf18, q[0].o18);
                void'(q.pop_front());
            end
            if (vld24) begin
                got24 = acc24; got18 = acc18; gotovf18 = ovf18;
                pulses++;
            end
        end
    end

    initial begin
        int p0;
        bit v, f, l;

        idle(3);
        @(posedge clk); #1; rstn = 1'b1;
        idle(2);

        // single beat group: 9 * 2 * 3
        beat(1, 1, 1, rep(8'd2), rep(8'd3));
        idle(9);
        check("t2_acc", got24, 54);

        // signed extremes
        beat(1, 1, 1, rep(8'h80), rep(8'h80));
        idle(9);
        check("t3_minmin", got24, 147456);
        beat(1, 1, 1, rep(8'hff), rep(8'd127));
        idle(9);
        check("t3_neg", got24, -1143);
        check("t3_neg18", got18, -1143);

        // four-beat group with bubbles: 9*(1+2+3+4)
        p0 = pulses;
        for (int k = 1; k <= 4; k++) begin
            beat(1, k == 1, k == 4, rep(8'd1), rep(8'(k)));
            idle($urandom_range(0, 3));
        end
        idle(9);
        check("t4_acc", got24, 90);
        check("t4_pulses", pulses - p0, 1);

        // first reasserted discards the open partial sum
        beat(1, 1, 0, one(8'd1), one(8'd4));
        beat(1, 0, 0, one(8'd1), one(8'd6));
        beat(1, 1, 1, one(8'd1), one(8'd5));
        idle(9);
        check("t5_acc", got24, 5);

        // overflow in the 18-bit instance
        beat(1, 1, 0, rep(8'd127), rep(8'd127));
        beat(1, 0, 1, rep(8'd127), rep(8'd127));
        idle(9);
        check("t6_acc24", got24, 290322);
`ifdef MAC_ACC_SAT_EN
        check("t6_acc18", got18, 131071);
        check("t6_ovf18", gotovf18, 1);
`else
        check("t6_acc18", got18, 28178);
        check("t6_ovf18", gotovf18, 0);
`endif
        beat(1, 1, 1, rep(8'd1), rep(8'd1));
        idle(9);
        check("t6_next_acc18", got18, 9);
        check("t6_next_ovf18", gotovf18, 0);

        // reset with beats in flight and a group open
        beat(1, 1, 0, rep(8'd3), rep(8'd3));
        beat(1, 0, 1, rep(8'd5), rep(8'd5));
        beat(1, 1, 0, rep(8'd7), rep(8'd7));
        p0 = pulses;
        do_reset(2);
        idle(10);
        check("t1_no_pulse", pulses - p0, 0);
        // last without first after reset starts from zero
        beat(1, 0, 1, rep(8'd1), rep(8'd2));
        idle(9);
        check("t1_clean", got24, 18);

        // randomized mixed traffic with a mid-stream reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset($urandom_range(1, 3));
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 3) == 0);
            l = ($urandom_range(0, 2) == 0);
            beat(v, f, l, rnd_vec(), rnd_vec());
        end

        // back-to-back single-beat groups every cycle
        for (int i = 0; i < 200; i++) beat(1, 1, 1, rnd_vec(), rnd_vec());

        // dense multi-beat groups without bubbles
        for (int i = 0; i < 300; i++)
            beat(1, (i % 3) == 0, (i % 3) == 2, rnd_vec(), rnd_vec());

        idle(12);
        check("drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
